// File: rtl/clkdiv_bank_pkg.sv
// ============================================================================
//  Module      : clkdiv_bank_pkg
//  Description : Shared constants for the clkdiv_bank divider bank: channel
//                index width and default divisor width / reset divisor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clkdiv_bank_pkg;

  // Width of the channel index carried on cfg_chan (addresses up to 16 channels)
  localparam int CHAN_W          = 4;
  // Default divisor / counter width
  localparam int DIV_W_DEF       = 20;
  // Default divisor loaded into each channel at reset
  localparam int DEFAULT_DIV_DEF = 2;

  // True when a channel index selects channel idx
  function automatic logic chan_hit(input logic [CHAN_W-1:0] chan, input int idx);
    return chan == CHAN_W'(idx);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clkdiv_chan.sv
// ============================================================================
//  Module      : clkdiv_chan
//  Description : One divider channel: counter, active divisor, pending
//                divisor with glitch-free reload, tick pulse and square wave.
//                Optional macro CLKDIV_BANK_SYNC_EN adds the sync input.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkdiv_chan
  import clkdiv_bank_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef CLKDIV_BANK_SYNC_EN
  input  logic             sync,
`endif
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             tick,
  output logic             sq,
  output logic             pending
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] pend_div;

  // Counter, divisor reload and output generation for this channel
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      div      <= DIV_W'(DEFAULT_DIV);
      pend_div <= '0;
      pending  <= 1'b0;
      tick     <= 1'b0;
      sq       <= 1'b0;
    end else begin
      // A write is only accepted while nothing is pending, so it never
      // collides with the pending-clear below on the same edge.
      if (wr) begin
        pend_div <= wr_div;
        pending  <= 1'b1;
      end
`ifdef CLKDIV_BANK_SYNC_EN
      if (sync) begin
        cnt  <= '0;
        tick <= 1'b0;
        sq   <= 1'b0;
        if (pending) begin
          div     <= pend_div;
          pending <= 1'b0;
        end
      end else
`endif
      if (!en || div == '0) begin
        // Idle channel: no tick, sq frozen; a pending value can load at once
        tick <= 1'b0;
        if (pending) begin
          div     <= pend_div;
          cnt     <= '0;
          pending <= 1'b0;
        end
      end else if (cnt == div - DIV_W'(1)) begin
        // Terminal count: the only point a running channel swaps divisors
        cnt  <= '0;
        tick <= 1'b1;
        sq   <= ~sq;
        if (pending) begin
          div     <= pend_div;
          pending <= 1'b0;
        end
      end else begin
        cnt  <= cnt + DIV_W'(1);
        tick <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/clkdiv_bank.sv
// ============================================================================
//  Module      : clkdiv_bank
//  Description : Bank of NCH independent programmable clock-enable dividers
//                with a shared divisor write port and per-channel backpressure.
//                Optional macro CLKDIV_BANK_SYNC_EN adds sync_i, which restarts
//                every channel aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkdiv_bank
  import clkdiv_bank_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    en_i,
`ifdef CLKDIV_BANK_SYNC_EN
  input  logic              sync_i,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHAN_W-1:0] cfg_chan,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NCH-1:0]    tick_o,
  output logic [NCH-1:0]    sq_o
);

  logic [NCH-1:0] pending;
  logic           busy;
  logic           accept;

  // Target channel busy if it still holds an unapplied divisor; indices
  // beyond NCH are never busy so such writes are accepted and dropped.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (chan_hit(cfg_chan, i) && pending[i]) begin
        busy = 1'b1;
      end
    end
  end

  assign cfg_ready = !rst && !busy;
  assign accept    = cfg_valid && cfg_ready;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_chan
      logic wr;
      assign wr = accept && chan_hit(cfg_chan, i);

      clkdiv_chan #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .en      (en_i[i]),
`ifdef CLKDIV_BANK_SYNC_EN
        .sync    (sync_i),
`endif
        .wr      (wr),
        .wr_div  (cfg_div),
        .tick    (tick_o[i]),
        .sq      (sq_o[i]),
        .pending (pending[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clkdiv_bank.sv
// ============================================================================
//  Module      : tb_clkdiv_bank
//  Description : Self-checking bench for clkdiv_bank. Stimulus pushes the
//                expected cfg_ready / tick_o / sq_o into a queue; a monitor
//                pops and compares. Reference model tracks cycles remaining
//                to each channel's next tick.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clkdiv_bank;
  import clkdiv_bank_pkg::*;

  localparam int NCH = 4;
  localparam int DIV_W = DIV_W_DEF;
  localparam int DEF = DEFAULT_DIV_DEF;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    en_i;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CHAN_W-1:0] cfg_chan;
  logic [DIV_W-1:0]  cfg_div;
  logic [NCH-1:0]    tick_o;
  logic [NCH-1:0]    sq_o;
`ifdef CLKDIV_BANK_SYNC_EN
  logic              sync_i;
`endif

  always #5 clk = ~clk;

  clkdiv_bank #(.NCH(NCH), .DIV_W(DIV_W), .DEFAULT_DIV(DEF)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en_i),
`ifdef CLKDIV_BANK_SYNC_EN
    .sync_i    (sync_i),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .tick_o    (tick_o),
    .sq_o      (sq_o)
  );

  typedef struct packed {
    logic           ready;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: divisor, cycles left until next tick, pending slot
  int m_div  [NCH];
  int m_left [NCH];
  int m_pv   [NCH];
  bit m_pf   [NCH];
  bit m_tick [NCH];
  bit m_sq   [NCH];

  function automatic bit model_ready(input int ch);
    if (ch < NCH) return !m_pf[ch];
    return 1'b1;
  endfunction

  // One clock cycle: drive inputs, predict, push expectation, advance
  task automatic step(input bit r, input logic [NCH-1:0] en, input bit v,
                      input int ch, input int dv, input bit s);
    exp_t e;
    bit   acc;
    rst       = r;
    en_i      = en;
    cfg_valid = v;
    cfg_chan  = CHAN_W'(ch);
    cfg_div   = DIV_W'(dv);
`ifdef CLKDIV_BANK_SYNC_EN
    sync_i    = s;
`endif
    e.ready = !r && model_ready(ch);
    acc     = v && e.ready;
    for (int i = 0; i < NCH; i++) begin
      if (r) begin
        m_div[i] = DEF; m_left[i] = DEF; m_pf[i] = 0; m_pv[i] = 0;
        m_tick[i] = 0; m_sq[i] = 0;
      end else begin
        if (s) begin
          m_tick[i] = 0; m_sq[i] = 0;
          if (m_pf[i]) begin m_div[i] = m_pv[i]; m_pf[i] = 0; end
          m_left[i] = m_div[i];
        end else if (!en[i] || m_div[i] == 0) begin
          m_tick[i] = 0;
          if (m_pf[i]) begin
            m_div[i] = m_pv[i]; m_pf[i] = 0; m_left[i] = m_div[i];
          end
        end else if (m_left[i] == 1) begin
          m_tick[i] = 1; m_sq[i] = !m_sq[i];
          if (m_pf[i]) begin m_div[i] = m_pv[i]; m_pf[i] = 0; end
          m_left[i] = m_div[i];
        end else begin
          m_left[i] = m_left[i] - 1; m_tick[i] = 0;
        end
        if (acc && ch == i) begin m_pf[i] = 1; m_pv[i] = dv; end
      end
      e.tick[i] = m_tick[i];
      e.sq[i]   = m_sq[i];
    end
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input logic [NCH-1:0] en);
    for (int k = 0; k < n; k++) step(0, en, 0, 0, 0, 0);
  endtask

  // Issue one write, waiting (bounded) until the model says it is accepted
  task automatic cfg_write(input int ch, input int dv, input logic [NCH-1:0] en);
    int tries = 0;
    while (!model_ready(ch) && tries < 40) begin
      idle(1, en);
      tries++;
    end
    checks++;
    if (tries >= 40) begin
      errors++;
      $display("FAIL write_wait ch=%0d still busy after %0d cycles, required ready", ch, tries);
    end
    step(0, en, 1, ch, dv, 0);
  endtask

  // Monitor: ready before the edge, tick/sq just after it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        checks++;
        if (cfg_ready !== q[0].ready) begin
          errors++;
          $display("FAIL cfg_ready t=%0t got %b exp %b", $time, cfg_ready, q[0].ready);
        end
      end
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (tick_o !== e.tick) begin
          errors++;
          $display("FAIL tick_o t=%0t got %b exp %b", $time, tick_o, e.tick);
        end
        checks++;
        if (sq_o !== e.sq) begin
          errors++;
          $display("FAIL sq_o t=%0t got %b exp %b", $time, sq_o, e.sq);
        end
      end
    end
  end

  initial begin
    int n;
    int got;
    logic [NCH-1:0] ren;
    rst = 1; en_i = '1; cfg_valid = 0; cfg_chan = '0; cfg_div = '0;
`ifdef CLKDIV_BANK_SYNC_EN
    sync_i = 0;
`endif
    @(posedge clk);
    #2;

    // Reset defaults, then free-run with all channels enabled
    for (int k = 0; k < 3; k++) step(1, '1, 0, 0, 0, 0);
    idle(12, '1);

    // Glitch-free reload on ch1: write D=5 while its counter is 0
    n = 0;
    while (m_left[1] != m_div[1] && n < 10) begin idle(1, '1); n++; end
    step(0, '1, 1, 1, 5, 0);
    idle(20, '1);

    // Backpressure: two back-to-back writes to ch2 with D=10
    got = 0; n = 0;
    while (got < 2 && n < 40) begin
      if (model_ready(2)) got++;
      step(0, '1, 1, 2, 10, 0);
      n++;
    end
    idle(25, '1);

    // Halt ch0 with D=0, then disable ch3 for 7 cycles
    cfg_write(0, 0, '1);
    idle(8, '1);
    idle(7, 4'b0111);
    idle(12, '1);

    // Out-of-range channel write is accepted and dropped
    step(0, '1, 1, 15, 7, 0);
    idle(6, '1);

`ifdef CLKDIV_BANK_SYNC_EN
    // Aligned restart of ch0 (D=3) and ch1 (D=4)
    cfg_write(0, 3, '1);
    cfg_write(1, 4, '1);
    n = 0;
    while ((m_pf[0] || m_pf[1]) && n < 30) begin idle(1, '1); n++; end
    step(0, '1, 0, 0, 0, 1);
    idle(14, '1);
`endif

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      ren = '1;
      for (int i = 0; i < NCH; i++) if ($urandom_range(0, 7) == 0) ren[i] = 1'b0;
      step(($urandom_range(0, 99) == 0), ren, ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 5)), int'($urandom_range(0, 9)),
`ifdef CLKDIV_BANK_SYNC_EN
           ($urandom_range(0, 39) == 0)
`else
           1'b0
`endif
          );
    end
    idle(2, '1);

    // Drain: every pushed expectation must have been consumed
    n = 0;
    while (q.size() > 0 && n < 10) begin @(posedge clk); n++; end
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue_left=%0d required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clkdiv_bank.md
CLKDIV_BANK -- requirements
Module: clkdiv_bank

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 20: divisor and counter width in bits.
REQ-003 SHALL have parameter DEFAULT_DIV, default 2: divisor loaded into every channel at reset.
REQ-004 SHALL have port clk, input, 1: the single clock; the block has no other clock.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port en_i, input, NCH: per-channel run enable.
REQ-007 SHALL have port cfg_valid, input, 1: divisor write request.
REQ-008 SHALL have port cfg_ready, output, 1: divisor write can be accepted.
REQ-009 SHALL have port cfg_chan, input, 4: target channel index.
REQ-010 SHALL have port cfg_div, input, DIV_W: new divisor value D.
REQ-011 SHALL have port tick_o, output, NCH: one-cycle clock-enable pulse per channel period.
REQ-012 SHALL have port sq_o, output, NCH: square wave per channel, toggling on each tick.

Function
REQ-013 SHALL, per channel, hold a registered counter cnt, an active divisor D, a pending divisor and a pending flag.
REQ-014 SHALL, when en_i=1 and D!=0 and cnt==D-1, on the edge set cnt to 0, tick_o to 1 and invert sq_o; otherwise running increments cnt and sets tick_o to 0.
  - tick period is D cycles; sq_o period is 2D cycles.
  - D=1: tick_o is held high and sq_o toggles every cycle.
REQ-015 SHALL treat D=0 as halted: cnt holds at 0, tick_o=0, sq_o holds its value.
REQ-016 SHALL, when en_i=0, hold cnt and sq_o and force tick_o to 0.
REQ-017 SHALL accept a write on a cycle where cfg_valid and cfg_ready are both high, storing cfg_div as pending and setting the pending flag the next cycle.
REQ-018 SHALL drive cfg_ready = !rst && !pending[cfg_chan]; cfg_ready is combinational from the registers and cfg_chan.
REQ-019 SHALL accept and discard a write with cfg_chan >= NCH, with no state change.
REQ-020 SHALL apply a pending divisor only at a terminal-count edge (cnt==D-1): D takes the pending value, cnt goes to 0 and the pending flag clears. This makes reload glitch-free.
REQ-021 SHALL apply a pending divisor on the next edge, with cnt set to 0, when the channel is disabled or D=0.
REQ-022 SHALL, for a write accepted in a terminal-count cycle, let that terminal count complete with the old D and apply the new value at the following terminal count.
REQ-023 SHALL keep channels fully independent; writes to one channel never disturb the cnt, tick_o or sq_o of another.

Reset
REQ-024 SHALL, with rst high at an edge, set every cnt to 0, tick_o to 0, sq_o to 0, D to DEFAULT_DIV and all pending flags to 0.
  - rst overrides any in-flight write, pending reload or sync.
REQ-025 SHALL resume at cnt=0 on the first edge after rst falls; the first tick occurs DEFAULT_DIV cycles later.

Configuration
REQ-026 SHALL, with macro CLKDIV_BANK_SYNC_EN defined, add input sync_i (1 bit).
  - A cycle with sync_i=1 sets every channel's cnt to 0, tick_o to 0 and sq_o to 0.
  - Any pending divisors are applied on that same edge.
REQ-027 SHALL, without CLKDIV_BANK_SYNC_EN, omit the sync_i port and its logic entirely.

Structure
REQ-028 SHALL place the channel-index width constant and the DIV_W/DEFAULT_DIV defaults in shared package clkdiv_bank_pkg.
REQ-029 SHALL implement each channel as sub-module clkdiv_chan (counter, divisor, pending, tick, sq), instantiated NCH times with a generate loop.

Verification
REQ-030 SHALL cover reset defaults: DEFAULT_DIV=2, en_i all 1, release rst -> tick_o pulses every 2nd cycle and sq_o has a period of 4 cycles on all channels.
REQ-031 SHALL cover glitch-free reload: with ch1 running at D=2, write D=5 when cnt=0 -> the current period completes with D=2, then ticks occur 5 cycles apart and no short pulse appears.
REQ-032 SHALL cover backpressure: two back-to-back writes to ch2 at D=10 -> cfg_ready goes low after the first write and stays low until the reload at ch2's terminal count; the second write is then accepted.
REQ-033 SHALL cover halt and disable: write D=0 to ch0 -> tick_o[0] stays 0 and sq_o[0] freezes; en_i[3]=0 for 7 cycles -> cnt[3] holds and counting resumes without skipping.
REQ-034 SHALL cover an out-of-range write: cfg_chan=15 with NCH=4 -> the write is accepted and no channel changes.
REQ-035 SHALL cover sync: with CLKDIV_BANK_SYNC_EN, set channels to D=3 and D=4 and pulse sync_i -> both channels restart aligned; their ticks coincide 12 cycles later.
